// File: rtl/onchip_mem_loader.sv
// onchip_mem_loader: packs an 8-bit valid/ready byte stream little-endian into
// 32-bit words and writes them to a single-port RAM from a programmed word
// address. It reports word count, an additive checksum, completion and overflow.
module onchip_mem_loader #(
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 11053
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_writedata,
  output logic [3:0]            mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic                  mem_clken,
  input  logic                  mem_waitrequest,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [7:0]            checksum
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_ERROR} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           buf_q, buf_d;
  logic [3:0]            be_q, be_d;
  logic [1:0]            idx_q, idx_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH:0]   wc_q, wc_d;
  logic [7:0]            cs_q, cs_d;
  logic                  error_q, error_d;
  logic                  done_q, done_d;
  logic                  clken_q;

  logic addr_ok, start_ok;

  assign addr_ok  = ({1'b0, addr_q} < DEPTH_L);
  assign start_ok = ({1'b0, start_addr} < DEPTH_L);

  // Outputs decoded from registered state only.
  assign in_ready       = (state_q == S_COLLECT) && addr_ok;
  assign mem_chipselect = (state_q == S_WRITE);
  assign mem_write      = (state_q == S_WRITE);
  assign mem_address    = addr_q;
  assign mem_writedata  = buf_q;
  assign mem_byteenable = be_q;
  assign mem_clken      = clken_q;
  assign busy           = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign done           = done_q;
  assign error          = error_q;
  assign word_count     = wc_q;
  assign checksum       = cs_q;

  // Next-state and datapath update for the load sequence.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    be_d    = be_q;
    idx_d   = idx_q;
    last_d  = last_q;
    wc_d    = wc_q;
    cs_d    = cs_q;
    error_d = error_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          if (!start_ok) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            state_d = S_COLLECT;
            addr_d  = start_addr;
            buf_d   = '0;
            be_d    = '0;
            idx_d   = '0;
            last_d  = 1'b0;
            wc_d    = '0;
            cs_d    = '0;
            error_d = 1'b0;
          end
        end
      end
      S_COLLECT: begin
        if (!addr_ok) begin
          // Memory full with no end-of-image seen: overflow.
          state_d = S_ERROR;
          error_d = 1'b1;
        end else if (in_valid) begin
          buf_d[{idx_q, 3'b000} +: 8] = in_data;
          be_d[idx_q]                 = 1'b1;
          cs_d                        = cs_q + in_data;
          idx_d                       = idx_q + 2'd1;
          if ((idx_q == 2'd3) || in_last) begin
            state_d = S_WRITE;
            last_d  = in_last;
          end
        end
      end
      S_WRITE: begin
        if (!mem_waitrequest) begin
          addr_d = addr_q + 1'b1;
          wc_d   = wc_q + 1'b1;
          buf_d  = '0;
          be_d   = '0;
          idx_d  = '0;
          if (last_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; clock enable rises after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      buf_q   <= '0;
      be_q    <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      wc_q    <= '0;
      cs_q    <= '0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
      clken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      be_q    <= be_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      wc_q    <= wc_d;
      cs_q    <= cs_d;
      error_q <= error_d;
      done_q  <= done_d;
      clken_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_onchip_mem_loader.sv
// Directed self-checking bench for onchip_mem_loader with a write-log RAM model.
module tb_onchip_mem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [13:0] start_addr;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [13:0] mem_address;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic        mem_clken;
  logic        mem_waitrequest;
  logic        busy;
  logic        done;
  logic        error;
  logic [14:0] word_count;
  logic [7:0]  checksum;

  int errors = 0;
  int checks = 0;

  // Write log filled by the RAM model on completed write edges.
  logic [13:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  logic [3:0]  wr_be   [0:63];
  int          wr_n = 0;

  onchip_mem_loader #(.ADDR_WIDTH(14), .DEPTH(11053)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken), .mem_waitrequest(mem_waitrequest),
    .busy(busy), .done(done), .error(error), .word_count(word_count),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset_n && mem_write && mem_chipselect && !mem_waitrequest && wr_n < 64) begin
      wr_addr[wr_n] <= mem_address;
      wr_data[wr_n] <= mem_writedata;
      wr_be[wr_n]   <= mem_byteenable;
      wr_n          <= wr_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [13:0] a);
    start = 1'b1; start_addr = a;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit ok = 0;
    in_data = d; in_last = l; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin ok = 1; break; end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL send_byte: in_ready never rose for byte %h", d); end
    else tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin seen = 1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (mem_write !== 1'b0 || mem_chipselect !== 1'b0) begin errors++; $display("FAIL rst_mem_write: got %b%b want 00", mem_write, mem_chipselect); end
    checks++; if (mem_clken !== 1'b0) begin errors++; $display("FAIL rst_clken: got %b want 0", mem_clken); end
    checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {busy, done, error}); end
    checks++; if (word_count !== 15'd0 || checksum !== 8'd0 || mem_address !== 14'd0) begin errors++; $display("FAIL rst_counts: got wc=%0d cs=%h addr=%h want 0", word_count, checksum, mem_address); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    checks++; if (mem_clken !== 1'b1) begin errors++; $display("FAIL clken_after_reset: got %b want 1", mem_clken); end
  endtask

  task automatic test_full_words();
    int base = wr_n;
    bit seen;
    pulse_start(14'h0010);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL fw_collect: busy=%b in_ready=%b want 1 1", busy, in_ready); end
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    checks++; if (mem_write !== 1'b1 || mem_address !== 14'h0010 || mem_writedata !== 32'h44332211 || mem_byteenable !== 4'hF || in_ready !== 1'b0)
      begin errors++; $display("FAIL fw_write_latency: wr=%b addr=%h data=%h be=%h rdy=%b want 1 0010 44332211 f 0", mem_write, mem_address, mem_writedata, mem_byteenable, in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL fw_resume: rdy=%b wr=%b want 1 0", in_ready, mem_write); end
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 1);
    wait_done(seen);
    checks++; if (!seen) begin errors++; $display("FAIL fw_done: done never pulsed"); end
    checks++; if (word_count !== 15'd2 || checksum !== 8'h64) begin errors++; $display("FAIL fw_counts: got wc=%0d cs=%h want 2 64", word_count, checksum); end
    checks++; if (wr_n - base !== 2) begin errors++; $display("FAIL fw_nwrites: got %0d want 2", wr_n - base); end
    checks++; if (wr_addr[base] !== 14'h0010 || wr_data[base] !== 32'h44332211 || wr_be[base] !== 4'hF) begin errors++; $display("FAIL fw_word0: got %h %h %h want 0010 44332211 f", wr_addr[base], wr_data[base], wr_be[base]); end
    checks++; if (wr_addr[base+1] !== 14'h0011 || wr_data[base+1] !== 32'h88776655 || wr_be[base+1] !== 4'hF) begin errors++; $display("FAIL fw_word1: got %h %h %h want 0011 88776655 f", wr_addr[base+1], wr_data[base+1], wr_be[base+1]); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fw_done_pulse: done=%b busy=%b want 0 0", done, busy); end
    checks++; if (word_count !== 15'd2 || checksum !== 8'h64) begin errors++; $display("FAIL fw_hold: got wc=%0d cs=%h want 2 64", word_count, checksum); end
  endtask

  task automatic test_partial();
    int base = wr_n;
    bit seen;
    pulse_start(14'h0000);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 1);
    wait_done(seen);
    checks++; if (!seen) begin errors++; $display("FAIL pw_done: done never pulsed"); end
    checks++; if (wr_n - base !== 1) begin errors++; $display("FAIL pw_nwrites: got %0d want 1", wr_n - base); end
    checks++; if (wr_addr[base] !== 14'h0000 || wr_data[base] !== 32'h00CCBBAA || wr_be[base] !== 4'h7) begin errors++; $display("FAIL pw_word: got %h %h %h want 0000 00ccbbaa 7", wr_addr[base], wr_data[base], wr_be[base]); end
    checks++; if (word_count !== 15'd1 || checksum !== 8'h31) begin errors++; $display("FAIL pw_counts: got wc=%0d cs=%h want 1 31", word_count, checksum); end
  endtask

  task automatic test_waitrequest();
    int base = wr_n;
    int wcyc = 0;
    bit seen;
    pulse_start(14'h0020);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    mem_waitrequest = 1'b1;
    send_byte(8'h04, 1);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (mem_write !== 1'b1 || mem_address !== 14'h0020 || mem_writedata !== 32'h04030201 || mem_byteenable !== 4'hF || in_ready !== 1'b0)
        begin errors++; $display("FAIL wr_stall_c%0d: wr=%b addr=%h data=%h be=%h rdy=%b want 1 0020 04030201 f 0", c, mem_write, mem_address, mem_writedata, mem_byteenable, in_ready); end
      wcyc++;
      if (c == 3) mem_waitrequest = 1'b0;
      tick();
    end
    checks++; if (wr_n - base !== 1) begin errors++; $display("FAIL wr_stall_nwrites: got %0d want 1", wr_n - base); end
    wait_done(seen);
    checks++; if (!seen || word_count !== 15'd1) begin errors++; $display("FAIL wr_stall_done: seen=%b wc=%0d want 1 1 (stall cycles %0d)", seen, word_count, wcyc); end
    tick();
  endtask

  task automatic test_overflow();
    int base = wr_n;
    pulse_start(14'd11052);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    in_data = 8'h05; in_valid = 1'b1; in_last = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b0 || mem_address !== 14'd11053 || error !== 1'b0) begin errors++; $display("FAIL ov_full: rdy=%b addr=%0d err=%b want 0 11053 0", in_ready, mem_address, error); end
    tick();
    checks++; if (error !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL ov_error: err=%b busy=%b rdy=%b want 1 0 0", error, busy, in_ready); end
    tick(); tick();
    in_valid = 1'b0;
    checks++; if (wr_n - base !== 1 || wr_addr[base] !== 14'd11052 || wr_data[base] !== 32'h04030201) begin errors++; $display("FAIL ov_writes: n=%0d addr=%0d data=%h want 1 11052 04030201", wr_n - base, wr_addr[base], wr_data[base]); end
    checks++; if (word_count !== 15'd1 || checksum !== 8'h0A || error !== 1'b1) begin errors++; $display("FAIL ov_counts: wc=%0d cs=%h err=%b want 1 0a 1", word_count, checksum, error); end
    pulse_start(14'h0040);
    checks++; if (error !== 1'b0 || busy !== 1'b1 || word_count !== 15'd0 || checksum !== 8'd0) begin errors++; $display("FAIL ov_restart: err=%b busy=%b wc=%0d cs=%h want 0 1 0 00", error, busy, word_count, checksum); end
    send_byte(8'h5A, 1);
    tick(); tick();
  endtask

  task automatic test_bad_addr();
    int base = wr_n;
    pulse_start(14'd11053);
    checks++; if (error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ba_error: err=%b busy=%b want 1 0", error, busy); end
    in_valid = 1'b1; in_data = 8'h77;
    tick(); tick();
    checks++; if (in_ready !== 1'b0 || mem_write !== 1'b0 || wr_n - base !== 0) begin errors++; $display("FAIL ba_nowrite: rdy=%b wr=%b n=%0d want 0 0 0", in_ready, mem_write, wr_n - base); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base = wr_n;
    pulse_start(14'h0030);
    send_byte(8'hDE, 0); send_byte(8'hAD, 0);
    pulse_start(14'h0100);
    checks++; if (mem_address !== 14'h0030 || busy !== 1'b1 || checksum !== 8'h8B) begin errors++; $display("FAIL rm_start_ignored: addr=%h busy=%b cs=%h want 0030 1 8b", mem_address, busy, checksum); end
    reset_n = 1'b0;
    #1;
    checks++; if ({busy, in_ready, mem_write, mem_clken, error, done} !== 6'b0 || mem_address !== 14'd0 || checksum !== 8'd0 || word_count !== 15'd0)
      begin errors++; $display("FAIL rm_outputs: flags=%b addr=%h cs=%h wc=%0d want 0", {busy, in_ready, mem_write, mem_clken, error, done}, mem_address, checksum, word_count); end
    tick();
    reset_n = 1'b1;
    tick(); tick();
    checks++; if (wr_n - base !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rm_nowrite: n=%0d busy=%b want 0 0", wr_n - base, busy); end
  endtask

  initial begin
    start = 1'b0; start_addr = '0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    mem_waitrequest = 1'b0; reset_n = 1'b0;
    test_reset();
    test_full_words();
    test_partial();
    test_waitrequest();
    test_overflow();
    test_bad_addr();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
